pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register; successor to the fixed 12-bit stage register.
- Adds a valid/ready handshake, a 2-entry skid buffer so `in_ready` is registered, a flush that injects a bubble, and a saturating stall counter for performance debug.
- Sits between any two processor pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 12, width of the stage payload.
- NOP_VALUE, 0 (DATA_W bits), payload driven on `out_data` when the stage holds a bubble.
- STALL_CNT_W, 8, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  payload from the upstream stage.
- in_valid  in  1  upstream payload is valid.
- in_ready  out  1  this stage accepts a payload this cycle; driven from a register.
- flush  in  1  synchronous squash of all held payloads (branch mispredict or exception).
- out_data  out  DATA_W  payload to the downstream stage.
- out_valid  out  1  `out_data` is valid.
- out_ready  in  1  downstream consumes `out_data` this cycle.
- stall_cycles  out  STALL_CNT_W  count of cycles with `out_valid` high and `out_ready` low; saturates.

Behaviour:
- Storage:
  - main entry `{main_v, main_d}` drives `out_valid`/`out_data` directly.
  - skid entry `{skid_v, skid_d}` holds at most one overflow payload.
  - `in_ready` = !skid_v, taken from the register (no combinational path from `out_ready`).
- Handshake events: accept = in_valid & in_ready; consume = out_valid & out_ready.
- States (encoded by main_v/skid_v):
  - EMPTY (0,0); FULL (1,0); SKID (1,1). The state (0,1) is illegal and never entered.
- Transitions, in priority order:
  - reset: go to EMPTY. main_d = NOP_VALUE, skid_d = NOP_VALUE, stall_cycles = 0, in_ready = 1, out_valid = 0.
  - flush, when not in reset: go to EMPTY. main_d = NOP_VALUE. Any same-cycle accept is discarded. in_ready = 1 on the next cycle. stall_cycles holds its value.
  - EMPTY:
    - accept → FULL, main_d = in_data.
  - FULL:
    - accept & consume → FULL, main_d = in_data.
    - accept & !consume → SKID, skid_d = in_data.
    - !accept & consume → EMPTY, main_d = NOP_VALUE.
    - otherwise hold.
  - SKID (in_ready = 0, so no accept):
    - consume → FULL, main_d = skid_d.
    - otherwise hold.
- Latency: an accepted payload appears on `out_data` the next cycle when the stage was EMPTY, or was FULL and consumed in the same cycle. Throughput is 1 payload per cycle with no bubbles while out_ready = 1.
- Ordering: strict FIFO. A payload is never duplicated or dropped except by flush or reset.
- out_data when out_valid = 0: always NOP_VALUE.
- stall_cycles:
  - increments when out_valid & !out_ready.
  - saturates at all-ones.
  - cleared only by reset.
- Reset or flush mid-transfer: the held payloads are lost and the upstream stage must re-issue them. An upstream stage that sees in_ready = 0 during the flush cycle treats its payload as not accepted.
- Widths: no arithmetic on the payload. The counter is unsigned with saturation compare.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding constants ST_EMPTY, ST_FULL, ST_SKID.
  - the default NOP encoding (all-zero instruction word), reused by every stage.
- One natural sub-module: sat_counter (parametrised width, inc, clear, saturating), instantiated for stall_cycles.
- The storage and control FSM stay in pipe_stage_reg.

Test Plan:
- Reset, then idle: assert reset for 2 cycles with in_valid = 1 and in_data = 12 → out_valid = 0, out_data = 0, in_ready = 1, stall_cycles = 0 throughout reset.
- Streaming: in_data = 12, 13, 14 on consecutive cycles, in_valid = 1, out_ready = 1 → out_data = 12, 13, 14 one cycle later each, out_valid continuous, in_ready stays 1.
- Backpressure: load 12, then with out_ready = 0 offer 13 then 14 → 13 goes to skid, in_ready drops to 0, 14 is held upstream. After 3 stalled cycles stall_cycles = 3. Then out_ready = 1 → outputs 12, 13, 14 in order with no loss.
- Flush in SKID: reach SKID holding 12 and 13, assert flush for 1 cycle with in_valid = 1 and in_data = 99 → next cycle out_valid = 0, out_data = 0, in_ready = 1, and 99 is never output.
- Stall counter saturation: STALL_CNT_W = 3, hold out_valid = 1 and out_ready = 0 for 10 cycles → stall_cycles = 7 and stays 7. Reset → 0.
- Custom bubble: NOP_VALUE = 12'h013, then flush → out_data = 12'h013 with out_valid = 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline stage encodings and default bubble word
package pipe_pkg;

    // Encoded as {main_v, skid_v}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b10,
        ST_SKID  = 2'b11
    } stage_state_e;

    localparam int NOP_WORD_W = 32;
    localparam logic [NOP_WORD_W-1:0] NOP_WORD = '0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - handshaked pipeline register with skid entry, flush and stall counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 12,
    parameter logic [DATA_W-1:0] NOP_VALUE   = DATA_W'(NOP_WORD),
    parameter int                STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_n;
    logic [DATA_W-1:0] skid_q, skid_n;
    logic              main_v, skid_v;
    logic              accept, consume;

    assign main_v    = state_q[1];
    assign skid_v    = state_q[0];
    // in_ready comes straight off the state flop, so out_ready never reaches it.
    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_n;
            skid_q  <= skid_n;
        end
    end

    always_comb begin
        state_d = state_q;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_n  = NOP_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        main_n  = in_data;
                    end
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        main_n = in_data;
                    end else if (accept) begin
                        state_d = ST_SKID;
                        skid_n  = in_data;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                        main_n  = NOP_VALUE;
                    end
                end
                ST_SKID: begin
                    if (consume) begin
                        state_d = ST_FULL;
                        main_n  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_n  = NOP_VALUE;
                end
            endcase
        end
    end

    // A flush cycle does not count as a stall.
    sat_counter #(
        .W(STALL_CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clear(reset),
        .inc  (out_valid & ~out_ready & ~flush),
        .count(stall_cycles)
    );

endmodule
